// File: rtl/ac_scan_ctrl_if.sv
// rtl/ac_scan_ctrl_if.sv - text stream and table lookup bus for the Aho-Corasick scan sequencer
interface ac_scan_ctrl_if #(
    parameter int STATE_W = 8,
    parameter int CHAR_W  = 4
);
    logic               char_valid;
    logic [CHAR_W-1:0]  char_in;
    logic               char_last;
    logic               char_ready;

    logic               tbl_req;
    logic [STATE_W-1:0] tbl_state;
    logic [CHAR_W-1:0]  tbl_chara;
    logic               tbl_ack;
    logic               tbl_hit;
    logic [STATE_W-1:0] tbl_next;
    logic [STATE_W-1:0] tbl_fail;
    logic               tbl_out;

    modport slave (
        input  char_valid, char_in, char_last,
        input  tbl_ack, tbl_hit, tbl_next, tbl_fail, tbl_out,
        output char_ready,
        output tbl_req, tbl_state, tbl_chara
    );

    modport master (
        output char_valid, char_in, char_last,
        output tbl_ack, tbl_hit, tbl_next, tbl_fail, tbl_out,
        input  char_ready,
        input  tbl_req, tbl_state, tbl_chara
    );
endinterface

// File: rtl/ac_scan_ctrl.sv
// rtl/ac_scan_ctrl.sv - Aho-Corasick goto/failure walk sequencer with match and completion reporting
module ac_scan_ctrl #(
    parameter int STATE_W  = 8,
    parameter int CHAR_W   = 4,
    parameter int POS_W    = 16,
    parameter int MAX_FAIL = 15
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    ac_scan_ctrl_if.slave      bus,
    output logic [STATE_W-1:0] o_now_state,
    output logic               o_match,
    output logic [STATE_W-1:0] o_match_state,
    output logic [POS_W-1:0]   o_match_pos,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_err
);
    localparam int FC_W = (MAX_FAIL < 1) ? 1 : $clog2(MAX_FAIL + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_DONE   = 2'd2
    } fsm_t;

    fsm_t               r_fsm;
    logic [CHAR_W-1:0]  r_char;
    logic               r_last;
    logic [STATE_W-1:0] r_state;
    logic [POS_W-1:0]   r_pos;
    logic [FC_W-1:0]    r_fail_cnt;
    logic               r_req;
    logic               r_match;
    logic [STATE_W-1:0] r_match_state;
    logic [POS_W-1:0]   r_match_pos;
    logic               r_done;
    logic               r_err;

    logic w_ack;
    logic w_take_fail;
    logic w_consume;
    logic w_overflow;

    // Only an acknowledged request in LOOKUP counts; stray acks are dropped.
    always_comb begin
        w_ack       = 1'b0;
        w_take_fail = 1'b0;
        w_consume   = 1'b0;
        w_overflow  = 1'b0;
        if (r_fsm == S_LOOKUP && r_req && bus.tbl_ack) begin
            w_ack = 1'b1;
        end
        if (w_ack && !bus.tbl_hit && r_state != '0) begin
            if (r_fail_cnt < FC_W'(MAX_FAIL)) begin
                w_take_fail = 1'b1;
            end else begin
                w_overflow = 1'b1;
            end
        end
        w_consume = w_ack && !w_take_fail;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fsm         <= S_IDLE;
            r_char        <= '0;
            r_last        <= 1'b0;
            r_state       <= '0;
            r_pos         <= '0;
            r_fail_cnt    <= '0;
            r_req         <= 1'b0;
            r_match       <= 1'b0;
            r_match_state <= '0;
            r_match_pos   <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else if (i_en) begin
            r_match <= 1'b0;
            r_done  <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (bus.char_valid) begin
                        r_char     <= bus.char_in;
                        r_last     <= bus.char_last;
                        r_fail_cnt <= '0;
                        r_req      <= 1'b1;
                        r_fsm      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    // A failure step leaves the request low for one cycle before re-issuing.
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end
                    if (w_take_fail) begin
                        r_state    <= bus.tbl_fail;
                        r_fail_cnt <= r_fail_cnt + 1'b1;
                        r_req      <= 1'b0;
                    end
                    if (w_consume) begin
                        r_req  <= 1'b0;
                        r_pos  <= r_pos + 1'b1;
                        r_done <= r_last;
                        r_fsm  <= r_last ? S_DONE : S_IDLE;
                        if (bus.tbl_hit) begin
                            r_state       <= bus.tbl_next;
                            r_match       <= bus.tbl_out;
                            r_match_state <= bus.tbl_next;
                            r_match_pos   <= r_pos;
                        end else begin
                            r_state <= '0;
                        end
                        if (w_overflow) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= '0;
                    r_pos   <= '0;
                    r_fsm   <= S_IDLE;
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.char_ready = i_en && !i_rst && (r_fsm == S_IDLE);
    assign bus.tbl_req    = r_req;
    assign bus.tbl_state  = r_state;
    assign bus.tbl_chara  = r_char;

    assign o_now_state   = r_state;
    assign o_match       = r_match;
    assign o_match_state = r_match_state;
    assign o_match_pos   = r_match_pos;
    assign o_done        = r_done;
    assign o_busy        = (r_fsm != S_IDLE);
    assign o_err         = r_err;
endmodule

// File: doc/ac_scan_ctrl.md
Name: ac_scan_ctrl

Overview:
- Sequencer for the Aho-Corasick goto/failure table lookup datapath.
- Accepts a stream of 4-bit text characters over a valid/ready handshake and issues one table lookup per step.
- Walks failure links until a goto hit or the root is reached, and keeps the current automaton state.
- Reports each match with its end position, and signals end-of-text completion.

Parameters:
STATE_W, 8, width of automaton state numbers
CHAR_W, 4, width of text character codes
POS_W, 16, width of text position counter
MAX_FAIL, 15, maximum consecutive failure transitions per character before error

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  reset, asynchronous, active-high
EN  input  1  global enable; 0 freezes FSM and counters, outputs hold
CHAR_VALID  input  1  text character available
CHAR_IN  input  CHAR_W  text character code
CHAR_LAST  input  1  qualifies CHAR_IN as final character of the text
CHAR_READY  output  1  controller accepts a character this cycle
TBL_REQ  output  1  lookup request to table reader
TBL_STATE  output  STATE_W  current state presented to table
TBL_CHARA  output  CHAR_W  character presented to table
TBL_ACK  input  1  table response valid (sampled only while TBL_REQ=1)
TBL_HIT  input  1  goto entry exists for (TBL_STATE, TBL_CHARA)
TBL_NEXT  input  STATE_W  goto target state, valid when TBL_HIT
TBL_FAIL  input  STATE_W  failure state of TBL_STATE
TBL_OUT  input  1  TBL_NEXT has a non-empty (merged) output set
NOW_STATE  output  STATE_W  current automaton state
MATCH  output  1  one-cycle pulse: match ends at MATCH_POS
MATCH_STATE  output  STATE_W  state reached at the match
MATCH_POS  output  POS_W  0-based index of character completing the match
DONE  output  1  one-cycle pulse after the last character is fully processed
BUSY  output  1  FSM not in IDLE
ERR  output  1  sticky: failure chain exceeded MAX_FAIL; cleared only by RST

Behaviour:
- Reset (async, immediate): FSM=IDLE, NOW_STATE=0, pos=0, fail_cnt=0. All outputs 0, except CHAR_READY, which is 1 once RST deasserts and EN=1. TBL_REQ drops combinationally with RST, aborting any lookup; a late TBL_ACK is ignored.
- Registers: char_r, last_r, state, pos, fail_cnt.
- FSM states: IDLE, LOOKUP, DONE_S.
- EN=0 holds every register. TBL_REQ, TBL_STATE and TBL_CHARA stay stable. CHAR_READY=0. TBL_ACK is ignored while EN=0.
- IDLE:
  - CHAR_READY = EN.
  - On CHAR_VALID & CHAR_READY: char_r<=CHAR_IN, last_r<=CHAR_LAST, fail_cnt<=0, go LOOKUP.
- LOOKUP:
  - TBL_REQ=1, TBL_STATE=state, TBL_CHARA=char_r. These are held stable until TBL_ACK.
  - TBL_ACK may arrive in the first LOOKUP cycle or any later cycle. Wait states are unbounded.
  - On ACK with TBL_HIT=1: state<=TBL_NEXT. If TBL_OUT, MATCH pulses the next cycle with MATCH_STATE=TBL_NEXT and MATCH_POS=pos. Character is consumed.
  - On ACK with TBL_HIT=0 and state==0: state stays 0, no match, character consumed.
  - On ACK with TBL_HIT=0 and state!=0 and fail_cnt<MAX_FAIL: state<=TBL_FAIL, fail_cnt++, stay in LOOKUP. TBL_REQ deasserts for exactly one cycle, then re-requests with the same char_r.
  - On ACK with TBL_HIT=0 and state!=0 and fail_cnt==MAX_FAIL: ERR<=1, state<=0, character consumed.
  - Character consumed: pos<=pos+1 (wraps modulo 2^POS_W). Go to DONE_S if last_r, else IDLE.
- DONE_S (one cycle):
  - DONE=1, state<=0, pos<=0, go IDLE.
  - A MATCH from the final character coincides with DONE.
- Throughput: minimum 2 cycles per character (IDLE accept + LOOKUP with same-cycle ACK). Each failure step adds 2 cycles plus table latency.
- NOW_STATE is registered and updates the cycle after ACK.
- CHAR_VALID held during LOOKUP is not accepted (CHAR_READY=0). The upstream source must hold its data until accepted.
- TBL_ACK when TBL_REQ=0 is ignored.
- MATCH_POS reflects pos before its increment.

Test Plan:
- Table for patterns "he","she","his","hers" (h=1,e=2,s=3,i=4,r=5); text "ushers" (u=6), CHAR_LAST on final s, 0-cycle table latency -> MATCH at pos 3 (state "she") and again at pos 3 for "he" via merged output. Then MATCH at pos 5 ("hers"), DONE one cycle after last ACK, NOW_STATE=0 afterwards.
- Root miss: text "uuu" -> no MATCH; each character takes exactly 2 cycles; NOW_STATE stays 0; DONE after 6 cycles.
- Failure chain: in state "sh", feed 'i' -> one failure step to "h" (TBL_REQ low one cycle), then hit to "hi"; fail_cnt 1; no ERR.
- Table latency of 3 cycles with random wait states -> TBL_STATE/TBL_CHARA stable while TBL_REQ=1; results identical to the 0-latency run.
- Table model with a cyclic failure chain and MAX_FAIL=2 -> ERR set after the third miss, state forced to 0, character consumed; ERR persists through DONE until RST.
- RST asserted mid-LOOKUP during a wait state -> TBL_REQ=0 immediately; after release NOW_STATE=0, MATCH_POS restarts at 0; a late TBL_ACK has no effect.
